// File: rtl/zero_remove.sv
// Guard-strip receiver: drops the zero half of each 2N frame and replays data at half rate.
// Optional ZERO_CHECK_EN adds a sticky guard_err on nonzero guard samples.
module zero_remove #(
  parameter int DW = 16,
  parameter int N  = 16,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sof,
  input  logic [DW-1:0] x_i,
  input  logic [DW-1:0] x_q,
  output logic [DW-1:0] y_i,
  output logic [DW-1:0] y_q,
  output logic          y_valid,
  output logic          guard_err
);

  localparam logic [CW-1:0] LAST = CW'(2*N-1);

  logic [CW-1:0]   cnt;
  logic [CW-1:0]   pos;
  logic            wbank;
  logic            primed;
  logic            resync;
  logic            is_data;
  logic            is_last;
  logic [CW-2:0]   waddr;
  logic [CW-2:0]   raddr;
  logic [2*DW-1:0] rd;

  logic [2*DW-1:0] bank0 [N];
  logic [2*DW-1:0] bank1 [N];

  assign pos     = sof ? '0 : cnt;
  assign resync  = sof && (cnt != '0);
  assign is_data = pos[CW-1];
  assign is_last = (pos == LAST);
  // N is a power of two, so pos-N is just the low bits
  assign waddr   = pos[CW-2:0];
  assign raddr   = pos[CW-1:1];
  assign rd      = wbank ? bank0[raddr] : bank1[raddr];

  always_ff @(posedge clk) begin
    if (!reset && is_data) begin
      if (wbank) bank1[waddr] <= {x_i, x_q};
      else       bank0[waddr] <= {x_i, x_q};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      wbank   <= 1'b0;
      primed  <= 1'b0;
      y_i     <= '0;
      y_q     <= '0;
      y_valid <= 1'b0;
    end else begin
      cnt <= is_last ? '0 : pos + 1'b1;
      if (resync) begin
        primed <= 1'b0;
      end else if (is_last) begin
        wbank  <= ~wbank;
        primed <= 1'b1;
      end
      if (primed && pos[0]) begin
        y_i     <= rd[2*DW-1:DW];
        y_q     <= rd[DW-1:0];
        y_valid <= 1'b1;
      end else begin
        y_i     <= '0;
        y_q     <= '0;
        y_valid <= 1'b0;
      end
    end
  end

`ifdef ZERO_CHECK_EN
  logic viol;

  assign viol = !is_data && ((x_i != '0) || (x_q != '0));

  always_ff @(posedge clk) begin
    if (reset)       guard_err <= 1'b0;
    else if (resync) guard_err <= viol;
    else if (viol)   guard_err <= 1'b1;
  end
`else
  assign guard_err = 1'b0;
`endif

endmodule

// File: tb/tb_zero_remove.sv
// Directed bench for zero_remove (N=16, DW=16).
module tb_zero_remove;

  logic        clk = 1'b0;
  logic        reset;
  logic        sof;
  logic [15:0] x_i;
  logic [15:0] x_q;
  logic [15:0] y_i;
  logic [15:0] y_q;
  logic        y_valid;
  logic        guard_err;

  int errors = 0;
  int checks = 0;
  logic g_exp = 1'b0;

  zero_remove #(.DW(16), .N(16), .CW(5)) dut (
    .clk(clk),
    .reset(reset),
    .sof(sof),
    .x_i(x_i),
    .x_q(x_q),
    .y_i(y_i),
    .y_q(y_q),
    .y_valid(y_valid),
    .guard_err(guard_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one frame (or its first np positions) starting at position 0
  task automatic run_frame(
    input string       name,
    input bit          s0,
    input int          np,
    input logic [15:0] di,
    input logic [15:0] dq,
    input bit          inc,
    input bit          ev,
    input logic [15:0] ei,
    input logic [15:0] eq,
    input bit          einc,
    input int          poke
  );
    logic [15:0] k;
    for (int p = 0; p < np; p++) begin
      sof = (p == 0) && s0;
      if (p >= 16) begin
        k   = 16'(p - 16);
        x_i = inc ? di + k : di;
        x_q = inc ? dq + k : dq;
      end else begin
        x_i = (p == poke) ? 16'd1 : 16'd0;
        x_q = 16'd0;
      end
      @(posedge clk);
      #1;
      if (ev && (p % 2 == 1)) begin
        k = 16'(p >> 1);
        chk($sformatf("%s valid p%0d", name, p), 32'(y_valid), 32'd1);
        chk($sformatf("%s y_i p%0d", name, p), 32'(y_i),
            32'(einc ? ei + k : ei));
        chk($sformatf("%s y_q p%0d", name, p), 32'(y_q),
            32'(einc ? eq + k : eq));
      end else begin
        chk($sformatf("%s idle p%0d", name, p), 32'(y_valid), 32'd0);
        chk($sformatf("%s zero p%0d", name, p), 32'({y_i, y_q}), 32'd0);
      end
      if (p == poke) begin
`ifdef ZERO_CHECK_EN
        g_exp = 1'b1;
`endif
        chk($sformatf("%s guard_set p%0d", name, p), 32'(guard_err),
            32'(g_exp));
      end
    end
    sof = 1'b0;
    chk({name, " guard_end"}, 32'(guard_err), 32'(g_exp));
  endtask

  initial begin
    reset = 1'b1;
    sof   = 1'b0;
    x_i   = 16'd0;
    x_q   = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst valid", 32'(y_valid), 32'd0);
    chk("rst y", 32'({y_i, y_q}), 32'd0);
    chk("rst guard", 32'(guard_err), 32'd0);
    reset = 1'b0;

    run_frame("f0", 1'b1, 32, 16'd100, 16'd200, 1'b1,
              1'b0, 16'd0, 16'd0, 1'b0, -1);
    run_frame("f1", 1'b0, 32, 16'd16, 16'd1016, 1'b1,
              1'b1, 16'd100, 16'd200, 1'b1, -1);
    run_frame("f2", 1'b1, 32, 16'd32, 16'd1032, 1'b1,
              1'b1, 16'd16, 16'd1016, 1'b1, -1);
    run_frame("f3", 1'b0, 32, 16'd48, 16'd1048, 1'b1,
              1'b1, 16'd32, 16'd1032, 1'b1, -1);

    // resync at position 7
    run_frame("f4p", 1'b0, 7, 16'd64, 16'd1064, 1'b1,
              1'b1, 16'd48, 16'd1048, 1'b1, -1);
    run_frame("rs0", 1'b1, 32, 16'd80, 16'd1080, 1'b1,
              1'b0, 16'd0, 16'd0, 1'b0, -1);
    run_frame("rs1", 1'b0, 32, 16'd96, 16'd1096, 1'b1,
              1'b1, 16'd80, 16'd1080, 1'b1, -1);

    // reset at position 20 during output
    run_frame("f7p", 1'b0, 20, 16'd112, 16'd1112, 1'b1,
              1'b1, 16'd96, 16'd1096, 1'b1, -1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst valid", 32'(y_valid), 32'd0);
    chk("midrst y", 32'({y_i, y_q}), 32'd0);
    reset = 1'b0;
    run_frame("pr0", 1'b0, 32, 16'd128, 16'd1128, 1'b1,
              1'b0, 16'd0, 16'd0, 1'b0, -1);

    // max values, then guard poke at position 5
    run_frame("max", 1'b0, 32, 16'hFFFF, 16'h8000, 1'b0,
              1'b1, 16'd128, 16'd1128, 1'b1, -1);
    run_frame("poke", 1'b0, 32, 16'd144, 16'd1144, 1'b1,
              1'b1, 16'hFFFF, 16'h8000, 1'b0, 5);
    run_frame("hold", 1'b0, 32, 16'd160, 16'd1160, 1'b1,
              1'b1, 16'd144, 16'd1144, 1'b1, -1);

    reset = 1'b1;
    @(posedge clk);
    #1;
    g_exp = 1'b0;
    chk("rst2 guard", 32'(guard_err), 32'd0);
    chk("rst2 valid", 32'(y_valid), 32'd0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
